crc24_attach_serial: RTL and testbench

//  Front stage of the turbo encoder path; feeds the encoder's serial frame input.

---
 rtl/crc24_attach_pkg.sv | 20 ++
 rtl/crc24_lfsr_bit.sv | 22 ++
 rtl/crc24_attach_serial.sv | 171 +++++++++++++++++
 tb/tb_crc24_attach_serial.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/crc24_attach_pkg.sv
// crc24_attach_pkg: shared defaults and FSM state encoding for the CRC24A attach stage.
`default_nettype none

package crc24_attach_pkg;

  localparam int          K_DEFAULT          = 1124;
  localparam int          CRC_W_DEFAULT      = 24;
  localparam logic [23:0] CRC_POLY_DEFAULT   = 24'h864CFB;
  localparam int          GAP_CYCLES_DEFAULT = 7000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_EMIT    = 2'd2,
    ST_GAP     = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/crc24_lfsr_bit.sv
// crc24_lfsr_bit: combinational single-bit CRC update, MSB-first, no reflection.
`default_nettype none

module crc24_lfsr_bit
  import crc24_attach_pkg::*;
#(
  parameter int               CRC_W    = CRC_W_DEFAULT,
  parameter logic [CRC_W-1:0] CRC_POLY = CRC_POLY_DEFAULT
) (
  input  logic [CRC_W-1:0] crc_in,
  input  logic             din,
  output logic [CRC_W-1:0] crc_out
);

  logic fb;

  assign fb      = crc_in[CRC_W-1] ^ din;
  assign crc_out = {crc_in[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);

endmodule

`default_nettype wire

// File: rtl/crc24_attach_serial.sv
// crc24_attach_serial: buffers a K-bit serial message, appends CRC24A, emits a gap-free frame.
// Optional macro CRC24_ERR_INJECT_EN adds err_inject to corrupt crc[0] of a chosen frame.
`default_nettype none

module crc24_attach_serial
  import crc24_attach_pkg::*;
#(
  parameter int               K          = K_DEFAULT,
  parameter int               CRC_W      = CRC_W_DEFAULT,
  parameter logic [CRC_W-1:0] CRC_POLY   = CRC_POLY_DEFAULT,
  parameter int               GAP_CYCLES = GAP_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_bit,
  input  logic in_last,
`ifdef CRC24_ERR_INJECT_EN
  input  logic err_inject,
`endif
  output logic in_ready,
  output logic ack,
  output logic out_bit,
  output logic busy,
  output logic err_len
);

  localparam int CNT_W = $clog2(K + CRC_W);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [CNT_W-1:0] LAST_MSG_IDX   = CNT_W'(K - 1);
  localparam logic [CNT_W-1:0] FIRST_CRC_IDX  = CNT_W'(K);
  localparam logic [CNT_W-1:0] LAST_FRAME_IDX = CNT_W'(K + CRC_W - 1);
  localparam logic [GAP_W-1:0] LAST_GAP_IDX   = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [CRC_W-1:0] crc;
  logic [CRC_W-1:0] crc_src;
  logic [CRC_W-1:0] crc_upd;
  logic [K-1:0]     msg_buf;
  logic             armed;
  logic             inject;
  logic             xfer;
  logic             at_last_idx;
  logic             len_ok;
  logic             len_bad;

  // A frame always starts from a zero CRC regardless of what the register holds in IDLE.
  assign crc_src = (state == ST_IDLE) ? '0 : crc;

  crc24_lfsr_bit #(
    .CRC_W    (CRC_W),
    .CRC_POLY (CRC_POLY)
  ) u_lfsr (
    .crc_in  (crc_src),
    .din     (in_bit),
    .crc_out (crc_upd)
  );

  // armed keeps in_ready low while reset is asserted and until the first clock after release.
  assign in_ready    = armed & ((state == ST_IDLE) | (state == ST_COLLECT));
  assign busy        = (state != ST_IDLE);
  assign xfer        = in_valid & in_ready;
  assign at_last_idx = (bit_cnt == LAST_MSG_IDX);
  assign len_ok      = xfer & in_last & at_last_idx;
  // in_last too early, or the K-th bit arriving without in_last.
  assign len_bad     = xfer & (in_last ^ at_last_idx);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ack       = 1'b0;
    out_bit   = 1'b0;
    case (state)
      ST_IDLE, ST_COLLECT: begin
        if (len_ok) begin
          state_nxt = ST_EMIT;
        end else if (len_bad) begin
          state_nxt = ST_IDLE;
        end else if (xfer) begin
          state_nxt = ST_COLLECT;
        end
      end
      ST_EMIT: begin
        ack = (bit_cnt == '0);
        if (bit_cnt < FIRST_CRC_IDX) begin
          out_bit = msg_buf[bit_cnt];
        end else begin
          out_bit = crc[CRC_W-1] ^ (inject & (bit_cnt == LAST_FRAME_IDX));
        end
        if (bit_cnt == LAST_FRAME_IDX) begin
          state_nxt = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt == LAST_GAP_IDX) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed   <= 1'b0;
      err_len <= 1'b0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      crc     <= '0;
      msg_buf <= '0;
    end else begin
      armed   <= 1'b1;
      err_len <= len_bad;
      case (state)
        ST_IDLE, ST_COLLECT: begin
          if (xfer) begin
            msg_buf[bit_cnt] <= in_bit;
            if (len_bad) begin
              bit_cnt <= '0;
              crc     <= '0;
            end else begin
              bit_cnt <= len_ok ? '0 : bit_cnt + 1'b1;
              crc     <= crc_upd;
            end
          end
        end
        ST_EMIT: begin
          // The CRC is shifted out of the MSB once the message part is done.
          if (bit_cnt >= FIRST_CRC_IDX) begin
            crc <= {crc[CRC_W-2:0], 1'b0};
          end
          bit_cnt <= (bit_cnt == LAST_FRAME_IDX) ? '0 : bit_cnt + 1'b1;
          gap_cnt <= '0;
        end
        ST_GAP: begin
          gap_cnt <= (gap_cnt == LAST_GAP_IDX) ? '0 : gap_cnt + 1'b1;
        end
        default: begin
          bit_cnt <= '0;
          gap_cnt <= '0;
        end
      endcase
    end
  end

`ifdef CRC24_ERR_INJECT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inject <= 1'b0;
    end else if ((state == ST_IDLE) && xfer) begin
      inject <= err_inject;
    end
  end
`else
  assign inject = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_crc24_attach_serial.sv
// tb_crc24_attach_serial: directed frames with hand-computed CRCs, queue scoreboard and monitor.
`default_nettype none

module tb_crc24_attach_serial;

  localparam int K     = 1124;
  localparam int CRC_W = 24;
  localparam int GAP   = 7000;
  localparam int FRAME = K + CRC_W;

  typedef struct {
    logic [K-1:0]     data;
    logic [CRC_W-1:0] crc;
    int               abort_at;
  } frame_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic in_bit;
  logic in_last;
  logic in_ready;
  logic ack;
  logic out_bit;
  logic busy;
  logic err_len;
`ifdef CRC24_ERR_INJECT_EN
  logic err_inject = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  frame_t exp_q[$];
  int     err_q[$];

  always #5 clk = ~clk;

  crc24_attach_serial dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .in_last    (in_last),
`ifdef CRC24_ERR_INJECT_EN
    .err_inject (err_inject),
`endif
    .in_ready   (in_ready),
    .ack        (ack),
    .out_bit    (out_bit),
    .busy       (busy),
    .err_len    (err_len)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [K-1:0] data, input logic [CRC_W-1:0] crc, input int abort_at);
    frame_t f;
    f.data     = data;
    f.crc      = crc;
    f.abort_at = abort_at;
    exp_q.push_back(f);
  endtask

  // stall > 0 drops in_valid on every stall-th cycle.
  task automatic send_frame(input logic [K-1:0] data, input int nbits, input int stall);
    int i   = 0;
    int cyc = 0;
    bit took;
    @(posedge clk); #1;
    while (i < nbits && cyc < 20000) begin
      in_valid = !(stall > 0 && (cyc % stall) == stall - 1);
      in_bit   = data[i];
      in_last  = (i == nbits - 1);
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk); #1;
      if (took) i++;
      cyc++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_bit   = 1'b0;
    if (i < nbits) check("send_timeout", 32'(i), 32'(nbits));
  endtask

  // Monitor: every ack starts a frame capture that is scored against the queue head.
  initial begin : monitor
    frame_t           f;
    logic [K-1:0]     got_data;
    logic [CRC_W-1:0] got_crc;
    bit               aborted;
    bit               ack_extra;
    int               abort_idx;
    int               mism;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) continue;
      if (err_len) begin
        check("err_len_expected", 32'(err_q.size() > 0), 32'd1);
        if (err_q.size() > 0) void'(err_q.pop_front());
      end
      if (ack) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 32'd1, 32'd0);
        end else begin
          f         = exp_q.pop_front();
          got_data  = '0;
          got_crc   = '0;
          aborted   = 1'b0;
          ack_extra = 1'b0;
          abort_idx = 0;
          got_data[0] = out_bit;
          for (int i = 1; i < FRAME; i++) begin
            @(negedge clk);
            if (rst !== 1'b1) begin
              aborted   = 1'b1;
              abort_idx = i;
              break;
            end
            if (ack) ack_extra = 1'b1;
            if (i < K) got_data[i] = out_bit;
            else       got_crc[FRAME-1-i] = out_bit;
          end
          mism = 0;
          for (int j = 0; j < K; j++) begin
            if ((f.abort_at == 0 || j < f.abort_at) && got_data[j] !== f.data[j]) mism++;
          end
          check("frame_data_mismatches", 32'(mism), 32'd0);
          check("frame_ack_once", 32'(ack_extra), 32'd0);
          if (f.abort_at > 0) begin
            check("frame_abort_index", 32'(abort_idx), 32'(f.abort_at));
          end else begin
            check("frame_complete", 32'(aborted), 32'd0);
            check("frame_crc", 32'(got_crc), 32'(f.crc));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #(90000 * 10);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [K-1:0] msg;
    int           blocked;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    in_last  = 1'b0;
    rst      = 1'b1;
    #2 rst   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({in_ready, ack, out_bit, busy, err_len}), 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", 32'(in_ready), 32'd1);

    // 1: all-zero message
    msg = '0;
    push_frame(msg, 24'h000000, 0);
    send_frame(msg, K, 0);
    @(negedge clk);
    check("t1_ack_latency", 32'(ack), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);

    // 2: single one in the last message bit -> CRC equals the polynomial
    msg = '0;
    msg[K-1] = 1'b1;
    push_frame(msg, 24'h864CFB, 0);
    send_frame(msg, K, 0);
    @(negedge clk);
    check("t2_ack_latency", 32'(ack), 32'd1);

    // 3: same frame with in_valid low every third cycle
    push_frame(msg, 24'h864CFB, 0);
    send_frame(msg, K, 3);
    @(negedge clk);
    check("t3_ack_latency", 32'(ack), 32'd1);

    // 4: short frame, in_last on bit 99
    msg = '0;
    msg[10] = 1'b1;
    msg[99] = 1'b1;
    err_q.push_back(1);
    send_frame(msg, 100, 0);
    @(negedge clk);
    check("t4_err_len", 32'(err_len), 32'd1);
    check("t4_ready_after_err", 32'(in_ready), 32'd1);
    check("t4_no_ack", 32'(ack), 32'd0);

    // 5: back-to-back frames; ones at K-2,K-1 -> 0C99F6, then one at K-2 -> 8AD50D
    msg = '0;
    msg[K-2] = 1'b1;
    msg[K-1] = 1'b1;
    push_frame(msg, 24'h0C99F6, 0);
    send_frame(msg, K, 0);
    @(negedge clk);
    check("t5_ack_latency", 32'(ack), 32'd1);
    blocked = 0;
    while (in_ready !== 1'b1 && blocked < 20000) begin
      blocked++;
      @(negedge clk);
    end
    check("t5_blocked_cycles", 32'(blocked), 32'(FRAME + GAP));
    msg = '0;
    msg[K-2] = 1'b1;
    push_frame(msg, 24'h8AD50D, 0);
    send_frame(msg, K, 0);
    @(negedge clk);
    check("t5b_ack_latency", 32'(ack), 32'd1);

    // 6: reset during emission of bit 500
    msg = '0;
    for (int i = 0; i < K; i += 3) msg[i] = 1'b1;
    msg[500] = 1'b1;
    push_frame(msg, 24'h000000, 500);
    send_frame(msg, K, 0);
    repeat (500) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("t6_outputs_in_reset", 32'({ack, out_bit, in_ready, busy}), 32'd0);
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("t6_idle_after_release", 32'({in_ready, busy}), 32'b10);
    repeat (50) @(posedge clk);
    #1;
    check("t6_no_stray_ack", 32'({ack, busy}), 32'd0);

    check("queues_drained", 32'(exp_q.size() + err_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
